// File: rtl/hs_data_rx.sv
// Receive side of a 4-phase req/ack handshake: synchronizes req_in, captures data_in
// into a one-entry output register and presents it downstream with valid/ready.
`timescale 1ns/1ps

module hs_data_rx #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic [DW-1:0]    data_in,
  output logic             ack_out,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             stall,
  output logic [CNT_W-1:0] xfer_cnt
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("hs_data_rx: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'b01,
    ACK_HIGH = 2'b10
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;
  logic                   cap_ok_s;
  logic                   capture_s;
  logic                   stall_s;
  logic                   ack_r;
  logic [DW-1:0]          dout_r;
  logic                   dout_valid_r;
  logic [CNT_W-1:0]       xfer_cnt_r;

  assign req_s    = sync_r[SYNC_STAGES-1];
  assign cap_ok_s = ~dout_valid_r | dout_ready;

  // req_in synchronizer chain; data_in is deliberately not synchronized
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_in};
    end
  end

  // State register; ack is its own flop so the remote side never sees decode glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= (state_nxt_s == ACK_HIGH);
    end
  end

  // Next-state, capture strobe and stall decode
  always_comb begin
    state_nxt_s = IDLE;
    capture_s   = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && cap_ok_s) begin
          state_nxt_s = ACK_HIGH;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          stall_s     = req_s;
        end
      end
      ACK_HIGH: begin
        if (req_s) begin
          state_nxt_s = ACK_HIGH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output register and transfer counter; a capture overrides a same-cycle drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r       <= {DW{1'b0}};
      dout_valid_r <= 1'b0;
      xfer_cnt_r   <= {CNT_W{1'b0}};
    end else if (capture_s) begin
      dout_r       <= data_in;
      dout_valid_r <= 1'b1;
      xfer_cnt_r   <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (dout_valid_r && dout_ready) begin
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= dout_valid_r;
    end
  end

  assign ack_out    = ack_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign stall      = stall_s;
  assign xfer_cnt   = xfer_cnt_r;

endmodule

// File: tb/tb_hs_data_rx.sv
// Self-checking bench for hs_data_rx: directed timing checks plus a randomized
// cross-clock sender whose words are tracked in an in-order expectation queue.
`timescale 1ns/1ps

module tb_hs_data_rx;

  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_in;
  logic [DW-1:0]    data_in;
  logic             ack_out;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             stall;
  logic [CNT_W-1:0] xfer_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          model_cnt = 0;
  logic [31:0] exp_q[$];
  logic        rnd_done = 1'b0;

  hs_data_rx #(.DW(DW), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .data_in    (data_in),
    .ack_out    (ack_out),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .stall      (stall),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check(tag, 32'(xfer_cnt), 32'(model_cnt % 16));
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int t;
    t = 0;
    while (ack_out !== v && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(ack_out), 32'(v));
  endtask

  task automatic send_word(input logic [31:0] w);
    data_in = w;
    exp_q.push_back(w);
    model_cnt++;
    @(negedge clk);
    req_in = 1'b1;
    wait_ack(1'b1, "send_ack_hi");
    @(negedge clk);
    req_in = 1'b0;
    wait_ack(1'b0, "send_ack_lo");
  endtask

  task automatic run_random(input realtime per, input realtime ofs, input int nw);
    rnd_done = 1'b0;
    fork
      begin
        int t;
        logic [31:0] w;
        @(posedge clk);
        #(ofs);
        for (int i = 0; i < nw; i++) begin
          w = $urandom;
          data_in = w;
          exp_q.push_back(w);
          model_cnt++;
          #(per);
          req_in = 1'b1;
          t = 0;
          while (ack_out !== 1'b1 && t < 5000) begin #(per); t++; end
          check("rnd_ack_hi", 32'(ack_out), 32'd1);
          data_in = $urandom;
          #(per);
          req_in = 1'b0;
          t = 0;
          while (ack_out !== 1'b0 && t < 5000) begin #(per); t++; end
          check("rnd_ack_lo", 32'(ack_out), 32'd0);
          #(per);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          dout_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    dout_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rnd_q_empty", 32'(exp_q.size()), 32'd0);
    check_cnt("rnd_cnt");
  endtask

  // Scoreboard: every word consumed downstream must be the oldest word sent
  always @(negedge clk) begin
    #2;
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_word", dout, exp_q.pop_front());
      end
    end
    if (!rst && stall) begin
      check("stall_ack", 32'(ack_out), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    req_in = 1'b0;
    data_in = 32'd0;
    dout_ready = 1'b0;
    #12;
    check("rst_ack", 32'(ack_out), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_cnt", 32'(xfer_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single transfer: req sampled at edge 0, ack at edge 2, release at edge 5
    dout_ready = 1'b1;
    data_in = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001);
    model_cnt++;
    req_in = 1'b1;
    @(negedge clk);
    check("t1_ack_e0", 32'(ack_out), 32'd0);
    @(negedge clk);
    check("t1_ack_e1", 32'(ack_out), 32'd0);
    check("t1_valid_e1", 32'(dout_valid), 32'd0);
    @(negedge clk);
    check("t1_ack_e2", 32'(ack_out), 32'd1);
    check("t1_valid_e2", 32'(dout_valid), 32'd1);
    check("t1_dout_e2", dout, 32'hA5A5_0001);
    @(negedge clk);
    check("t1_valid_e3", 32'(dout_valid), 32'd0);
    check("t1_cnt_e3", 32'(xfer_cnt), 32'd1);
    @(negedge clk);
    req_in = 1'b0;
    @(negedge clk);
    check("t1_ack_e5", 32'(ack_out), 32'd1);
    @(negedge clk);
    check("t1_ack_e6", 32'(ack_out), 32'd1);
    @(negedge clk);
    check("t1_ack_e7", 32'(ack_out), 32'd0);

    // Backpressure: 0x1 sits unconsumed while a second request carries 0x2
    dout_ready = 1'b0;
    send_word(32'h1);
    check("bp_valid1", 32'(dout_valid), 32'd1);
    check("bp_dout1", dout, 32'h1);
    data_in = 32'h2;
    exp_q.push_back(32'h2);
    model_cnt++;
    req_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("bp_stall", 32'(stall), 32'd1);
      check("bp_ack_low", 32'(ack_out), 32'd0);
      @(negedge clk);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check("bp_dout2", dout, 32'h2);
    check("bp_valid2", 32'(dout_valid), 32'd1);
    check("bp_ack_rise", 32'(ack_out), 32'd1);
    check("bp_stall_off", 32'(stall), 32'd0);
    req_in = 1'b0;
    wait_ack(1'b0, "bp_ack_lo");
    dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_drained", 32'(dout_valid), 32'd0);
    check_cnt("bp_cnt");

    // Back-to-back words 0..7
    for (int i = 0; i < 8; i++) send_word(32'(i));
    repeat (2) @(negedge clk);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
    check_cnt("b2b_cnt");

    // Reset in ACK_HIGH with an unconsumed word, req still high afterwards
    dout_ready = 1'b0;
    data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    req_in = 1'b1;
    wait_ack(1'b1, "rm_ack_hi");
    check("rm_valid_pre", 32'(dout_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rm_ack", 32'(ack_out), 32'd0);
    check("rm_valid", 32'(dout_valid), 32'd0);
    check("rm_dout", dout, 32'd0);
    check("rm_cnt", 32'(xfer_cnt), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    model_cnt++;
    @(negedge clk);
    check("rm_ack_e0", 32'(ack_out), 32'd0);
    @(negedge clk);
    check("rm_ack_e1", 32'(ack_out), 32'd0);
    @(negedge clk);
    check("rm_ack_e2", 32'(ack_out), 32'd1);
    check("rm_dout_e2", dout, 32'hDEAD_BEEF);
    check("rm_cnt_e2", 32'(xfer_cnt), 32'd1);
    dout_ready = 1'b1;
    req_in = 1'b0;
    wait_ack(1'b0, "rm_ack_lo");

    // Counter wrap: 17 transfers from reset on a 4-bit counter
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) send_word($urandom);
    repeat (2) @(negedge clk);
    check("wrap_cnt", 32'(xfer_cnt), 32'd1);
    check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // Randomized cross-clock sender: slow, fast and equal-rate with phase offset
    run_random(30.0, 0.0, 334);
    run_random(10.0 / 3.0, 1.1, 333);
    run_random(10.0, 3.7, 333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
